seg_scan_mux: RTL and testbench
===============================

// Module: seg_scan_mux
// PURPOSE
//  Downstream display stage behind the countdown/traffic-light core.
//  - Time-multiplexes its two 7-segment digit patterns (high_seg, low_seg) onto one shared
//    segment bus with one-hot digit enables, with a dead-time blank between digits.
//  - Decodes the 2-bit light code into discrete lamp drives, including a fault blink.
// PARAMETERS
//  SCAN_DIV   5    clock cycles each digit is driven (>=1)
//  BLANK_CYC  1    dead cycles between digits, all outputs dark (>=0; 0 = no blank slots)
//  BLINK_DIV  250  half-period in cycles of the fault blink (>=1)
// PORTS
//  clk       in   1  system clock (1 kHz nominal)
//  rst       in   1  asynchronous, active-high reset
//  en        in   1  scan enable; 0 = display dark
//  high_seg  in   7  tens digit pattern {g,f,e,d,c,b,a}, 1 = lit
//  low_seg   in   7  units digit pattern, same encoding
//  light     in   2  00 red, 01 green, 10 yellow, 11 fault
//  seg_out   out  7  shared segment bus, 1 = lit
//  dig_sel   out  2  one-hot digit enable: 10 = high digit, 01 = low digit, 00 = none
//  led       out  3  {red,yellow,green} lamp drive, 1 = on
// BEHAVIOUR
//  Registers and reset
//  - All outputs are registered.
//  - rst clears seg_out, dig_sel, led, shadow regs, counters and blink phase to 0.
//  - rst places the FSM in IDLE; it takes effect immediately, including mid-frame.
//  Scan FSM: IDLE -> HI -> BLK1 -> LO -> BLK2 -> HI ...
//  - IDLE: dig_sel=00, seg_out=0. Leaves on the first edge with en=1.
//  - Entering HI (from IDLE or BLK2/LO): on that same edge, sample high_seg and low_seg
//    into shadow regs, so both digits of a frame always show the same sample.
//  - HI lasts exactly SCAN_DIV cycles: dig_sel=10, seg_out=hi_shadow.
//  - BLK1 and BLK2 last exactly BLANK_CYC cycles each: dig_sel=00, seg_out=0.
//  - BLANK_CYC=0: BLK1/BLK2 are skipped; HI->LO and LO->HI are direct.
//  - LO lasts exactly SCAN_DIV cycles: dig_sel=01, seg_out=lo_shadow.
//  - Frame period is 2*(SCAN_DIV+BLANK_CYC) cycles.
//  - dig_sel never has both bits set, and never has a bit set in the same cycle
//    seg_out shows the other digit's data.
//  - Input changes mid-frame are not visible until the next HI entry.
//  Enable
//  - en=0 in any state: the next edge goes to IDLE, outputs dark from that cycle, slot
//    counter cleared.
//  - Re-asserting en starts a fresh frame with a full-length HI slot.
//  Lamp decode (1-cycle latency from light; independent of en)
//  - 00 -> 100; 01 -> 001; 10 -> 010.
//  - 11 -> led = {blink,0,0}:
//    - blink=1 on the first fault cycle, then toggles every BLINK_DIV cycles.
//    - The blink counter clears whenever light != 11.
// CONFIGURATION
//  LZ_BLANK_EN
//  - Defined: if hi_shadow == 7'h3F (digit '0'), seg_out is forced to 0 during HI.
//    dig_sel and slot timing are unchanged (leading-zero suppression).
//  - Undefined: hi_shadow is shown unmodified; 7'h3F displays as '0'.
// TESTING (defaults SCAN_DIV=5, BLANK_CYC=1, BLINK_DIV=250)
//  1. rst=1 mid-frame, en=1 -> same cycle: seg_out=0, dig_sel=00, led=000; held while rst=1.
//  2. en=1, high_seg=7'h06, low_seg=7'h5B ->
//     5 cyc {10,06}, 1 cyc {00,00}, 5 cyc {01,5B}, 1 cyc {00,00}; repeats every 12.
//  3. high_seg 06->66 during LO slot -> remaining LO/BLK2 unchanged; next HI shows 66.
//  4. light=01 -> led=001 next cycle; light=11 for 600 cyc ->
//     led=100 for cyc 1-250, 000 for 251-500, 100 from 501.
//  5. en=0 on 3rd HI cycle -> next cycle dig_sel=00, seg_out=0;
//     en=1 again -> HI for full 5 cycles.
//  6. high_seg=7'h3F -> HI slot: seg_out=00 with LZ_BLANK_EN, 3F without;
//     dig_sel=10 in both builds.

Source files
------------

// File: rtl/seg_scan_mux.sv
// Two-digit 7-segment scan multiplexer with blanking and traffic-lamp decode.
// Optional build macro LZ_BLANK_EN: suppress a leading '0' on the high digit.
module seg_scan_mux #(
    parameter int SCAN_DIV  = 5,
    parameter int BLANK_CYC = 1,
    parameter int BLINK_DIV = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [6:0] high_seg,
    input  logic [6:0] low_seg,
    input  logic [1:0] light,
    output logic [6:0] seg_out,
    output logic [1:0] dig_sel,
    output logic [2:0] led
);

    localparam int MAXC = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int BW   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [CW-1:0] HI_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] BK_LAST =
        (BLANK_CYC > 0) ? CW'(BLANK_CYC - 1) : '0;
    localparam logic [BW-1:0] BL_LAST = BW'(BLINK_DIV - 1);
    localparam logic          HAS_BLK = (BLANK_CYC > 0);

`ifdef LZ_BLANK_EN
    localparam logic LZ_ON = 1'b1;
`else
    localparam logic LZ_ON = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE,
        S_HI,
        S_BLK1,
        S_LO,
        S_BLK2
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic [6:0]    hi_sh;
    logic [6:0]    lo_sh;
    logic [6:0]    hi_nx;
    logic [6:0]    lo_nx;
    logic          enter_hi;
    logic [6:0]    seg_nx;
    logic [1:0]    dig_nx;

    logic [BW-1:0] bcnt;
    logic          bph;
    logic [2:0]    led_nx;

    // State, slot counter and frame shadows
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            cnt   <= '0;
            hi_sh <= '0;
            lo_sh <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            hi_sh <= hi_nx;
            lo_sh <= lo_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (!en) begin
            state_nx = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE: state_nx = S_HI;
                S_HI: begin
                    if (cnt == HI_LAST)
                        state_nx = HAS_BLK ? S_BLK1 : S_LO;
                end
                S_BLK1: begin
                    if (cnt == BK_LAST)
                        state_nx = S_LO;
                end
                S_LO: begin
                    if (cnt == HI_LAST)
                        state_nx = HAS_BLK ? S_BLK2 : S_HI;
                end
                S_BLK2: begin
                    if (cnt == BK_LAST)
                        state_nx = S_HI;
                end
                default: state_nx = S_IDLE;
            endcase
        end
    end

    // Both digits are latched together so one frame never mixes samples
    always_comb begin
        enter_hi = (state_nx == S_HI) && (state != S_HI);
        hi_nx    = enter_hi ? high_seg : hi_sh;
        lo_nx    = enter_hi ? low_seg : lo_sh;
        if ((state_nx != state) || (state_nx == S_IDLE))
            cnt_nx = '0;
        else
            cnt_nx = cnt + CW'(1);
    end

    always_comb begin
        seg_nx = '0;
        dig_nx = '0;
        unique case (state_nx)
            S_HI: begin
                dig_nx = 2'b10;
                seg_nx = (LZ_ON && (hi_nx == 7'h3F)) ? 7'h00 : hi_nx;
            end
            S_LO: begin
                dig_nx = 2'b01;
                seg_nx = lo_nx;
            end
            default: begin
                seg_nx = '0;
                dig_nx = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_out <= '0;
            dig_sel <= '0;
        end else begin
            seg_out <= seg_nx;
            dig_sel <= dig_nx;
        end
    end

    // Phase 0 is the lit half so the first fault cycle shows red
    always_comb begin
        led_nx = 3'b000;
        unique case (light)
            2'b00:   led_nx = 3'b100;
            2'b01:   led_nx = 3'b001;
            2'b10:   led_nx = 3'b010;
            2'b11:   led_nx = {~bph, 2'b00};
            default: led_nx = 3'b000;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led  <= '0;
            bcnt <= '0;
            bph  <= 1'b0;
        end else begin
            led <= led_nx;
            if (light == 2'b11) begin
                if (bcnt == BL_LAST) begin
                    bcnt <= '0;
                    bph  <= ~bph;
                end else begin
                    bcnt <= bcnt + BW'(1);
                end
            end else begin
                bcnt <= '0;
                bph  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed bench for seg_scan_mux at default parameters.
// Honors LZ_BLANK_EN in the leading-zero step.
module tb_seg_scan_mux;

    logic       clk;
    logic       rst;
    logic       en;
    logic [6:0] high_seg;
    logic [6:0] low_seg;
    logic [1:0] light;
    logic [6:0] seg_out;
    logic [1:0] dig_sel;
    logic [2:0] led;

    int vectors;
    int miscompares;

    seg_scan_mux dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .high_seg (high_seg),
        .low_seg  (low_seg),
        .light    (light),
        .seg_out  (seg_out),
        .dig_sel  (dig_sel),
        .led      (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [15:0] obs,
                       input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_scan(input string tag,
                            input logic [1:0] d,
                            input logic [6:0] s);
        chk(tag, {7'd0, dig_sel, seg_out}, {7'd0, d, s});
    endtask

    initial begin
        int         m;
        logic [6:0] hs;
        logic [1:0] ed;
        logic [6:0] es;
        logic [2:0] el;

        vectors     = 0;
        miscompares = 0;
        rst      = 1'b1;
        en       = 1'b0;
        high_seg = 7'h00;
        low_seg  = 7'h00;
        light    = 2'b00;

        repeat (2) @(negedge clk);
        chk_scan("reset_scan", 2'b00, 7'h00);
        chk("reset_led", {13'd0, led}, 16'h0000);

        rst      = 1'b0;
        en       = 1'b1;
        high_seg = 7'h06;
        low_seg  = 7'h5B;
        light    = 2'b01;

        for (int i = 0; i < 51; i++) begin
            @(negedge clk);
            m  = i % 12;
            hs = (i >= 36) ? 7'h66 : 7'h06;
            if (m < 5) begin
                ed = 2'b10;
                es = hs;
            end else if (m == 5 || m == 11) begin
                ed = 2'b00;
                es = 7'h00;
            end else begin
                ed = 2'b01;
                es = 7'h5B;
            end
            chk_scan($sformatf("scan_%0d", i), ed, es);
            if (i == 0)
                chk("led_green", {13'd0, led}, 16'h0001);
            if (i == 31)
                high_seg = 7'h66;
            if (i == 50)
                en = 1'b0;
        end

        @(negedge clk);
        chk_scan("en_off_1", 2'b00, 7'h00);
        @(negedge clk);
        chk_scan("en_off_2", 2'b00, 7'h00);
        en = 1'b1;

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk_scan($sformatf("reen_hi_%0d", i), 2'b10, 7'h66);
        end
        @(negedge clk);
        chk_scan("reen_blk", 2'b00, 7'h00);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_scan($sformatf("reen_lo_%0d", i), 2'b01, 7'h5B);
        end

        repeat (5) @(negedge clk);
        chk_scan("pre_rst_hi", 2'b10, 7'h66);
        rst = 1'b1;
        #1;
        chk_scan("rst_async", 2'b00, 7'h00);
        chk("rst_async_led", {13'd0, led}, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_scan($sformatf("rst_hold_%0d", i), 2'b00, 7'h00);
            chk("rst_hold_led", {13'd0, led}, 16'h0000);
        end

        en  = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("lamp_green", {13'd0, led}, 16'h0001);
        chk_scan("idle_dark", 2'b00, 7'h00);

        light = 2'b11;
        for (int c = 1; c <= 600; c++) begin
            @(negedge clk);
            el = (c <= 250 || c > 500) ? 3'b100 : 3'b000;
            chk($sformatf("blink_%0d", c), {13'd0, led}, {13'd0, el});
        end

        light = 2'b10;
        @(negedge clk);
        chk("lamp_yellow", {13'd0, led}, 16'h0002);
        light = 2'b11;
        @(negedge clk);
        chk("fault_restart_1", {13'd0, led}, 16'h0004);
        @(negedge clk);
        chk("fault_restart_2", {13'd0, led}, 16'h0004);

        light    = 2'b00;
        high_seg = 7'h3F;
        en       = 1'b1;
        @(negedge clk);
        chk("lamp_red", {13'd0, led}, 16'h0004);
`ifdef LZ_BLANK_EN
        chk_scan("lz_hi", 2'b10, 7'h00);
`else
        chk_scan("lz_hi", 2'b10, 7'h3F);
`endif
        repeat (5) @(negedge clk);
        chk_scan("lz_blk", 2'b00, 7'h00);
        @(negedge clk);
        chk_scan("lz_lo", 2'b01, 7'h5B);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
